// File: rtl/baud_pkg.sv
// Shared constants, tick bundle type and the phase-width helper for the baud tick generator.
package baud_pkg;

  localparam int BAUD_DEFAULT_DIV = 651;
  localparam int BAUD_OVERSAMPLE  = 16;
  localparam int MIN_DIV          = 2;

  // The three registered tick pulses travel together as one bundle.
  typedef struct packed {
    logic os;
    logic mid;
    logic bnd;
  } tick_t;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_generator_if.sv
// Control/status bundle between a UART bit engine (master) and the baud tick generator (slave).
interface baud_tick_generator_if #(
  parameter int DIV_WIDTH  = 16,
  parameter int FRAC_WIDTH = 4
);
  logic                  en;
  logic                  resync;
  logic                  div_wr;
  logic [DIV_WIDTH-1:0]  div_data;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic                  div_busy;
  logic                  cfg_err;
  logic                  os_tick;
  logic                  mid_tick;
  logic                  bit_tick;

  modport master (
    output en, resync, div_wr, div_data, div_frac,
    input  div_busy, cfg_err, os_tick, mid_tick, bit_tick
  );

  modport slave (
    input  en, resync, div_wr, div_data, div_frac,
    output div_busy, cfg_err, os_tick, mid_tick, bit_tick
  );
endinterface

// File: rtl/baud_frac_accum.sv
// Fractional divisor accumulator: flags oversample periods that must last one extra cycle.
// Only instantiated when BAUD_FRAC_EN is defined.
module baud_frac_accum #(
  parameter int FRAC_WIDTH = 4
)(
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_step,
  input  logic [FRAC_WIDTH-1:0] i_frac,
  output logic                  o_extend
);

  logic [FRAC_WIDTH-1:0] r_acc;
  logic [FRAC_WIDTH:0]   w_sum;

  // The carry of this period's addition stretches the period currently running.
  assign w_sum    = {1'b0, r_acc} + {1'b0, i_frac};
  assign o_extend = w_sum[FRAC_WIDTH];

  // Advance once per completed oversample period; a bit-phase restart clears the residue.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_step) begin
      r_acc <= w_sum[FRAC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Programmable baud tick source: oversample, mid-bit and bit-boundary ticks for uart_rx/uart_tx.
// Optional feature macro: BAUD_FRAC_EN adds a fractional divisor (div_frac) via baud_frac_accum;
// without it div_frac is ignored and all periods are whole multiples of the integer divisor.
module baud_tick_generator
  import baud_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int OVERSAMPLE  = BAUD_OVERSAMPLE,
  parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV,
  parameter int FRAC_WIDTH  = 4
)(
  input  logic                  clk_in,
  input  logic                  rst_n,
  baud_tick_generator_if.slave  bus
);

  localparam int                PH_W    = clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]   PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]   PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);

  // Divisors below the minimum cannot produce distinct ticks; they are raised to the minimum.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] val);
    return (val < DIV_MIN) ? DIV_MIN : val;
  endfunction

  logic [DIV_WIDTH-1:0] r_div_q;
  logic [DIV_WIDTH-1:0] r_div_pend;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [PH_W-1:0]      r_phase;
  logic                 r_busy;
  logic                 r_cfg_err;
  tick_t                r_ticks;

  logic [DIV_WIDTH:0]   w_term;
  logic                 w_extend;
  logic                 w_wrap;
  logic                 w_tick;
  logic                 w_bit_wrap;
  logic                 w_apply;

`ifdef BAUD_FRAC_EN
  logic [FRAC_WIDTH-1:0] r_frac_q;
  logic [FRAC_WIDTH-1:0] r_frac_pend;

  baud_frac_accum #(
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_frac_accum (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .i_clr    (bus.resync),
    .i_step   (w_tick),
    .i_frac   (r_frac_q),
    .o_extend (w_extend)
  );
`else
  logic [FRAC_WIDTH-1:0] w_unused_frac;

  assign w_unused_frac = bus.div_frac;
  assign w_extend      = 1'b0;
`endif

  // Terminal count is div_q-1 (plus one on a stretched fractional period). The compare is
  // ">=" because a divisor applied while paused may be shorter than the count already reached;
  // such a period then ends on the next enabled cycle.
  assign w_term     = {1'b0, r_div_q} - (DIV_WIDTH + 1)'(1) + {{DIV_WIDTH{1'b0}}, w_extend};
  assign w_wrap     = bus.en & ({1'b0, r_cnt} >= w_term);
  assign w_tick     = w_wrap & ~bus.resync;
  assign w_bit_wrap = w_tick & (r_phase == PH_LAST);
  assign w_apply    = r_busy & (w_bit_wrap | bus.resync | ~bus.en);

  // Oversample counter and bit phase; resync wins over counting and discards a coincident wrap.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (bus.resync) begin
      r_cnt   <= '0;
      r_phase <= '0;
    end else if (w_wrap) begin
      r_cnt   <= '0;
      r_phase <= r_phase + PH_W'(1);
    end else if (bus.en) begin
      r_cnt   <= r_cnt + DIV_WIDTH'(1);
    end
  end

  // Tick pulses are registered one cycle after the wrap that produces them.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_ticks <= '0;
    end else begin
      r_ticks.os  <= w_tick;
      r_ticks.mid <= w_tick & (r_phase == PH_MID);
      r_ticks.bnd <= w_bit_wrap;
    end
  end

  // Divisor reload: a write parks in the pending register and takes effect only at a point
  // where changing the period cannot split a bit (boundary, resync, or while stopped).
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_div_q     <= DIV_RST;
      r_div_pend  <= DIV_RST;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
`ifdef BAUD_FRAC_EN
      r_frac_q    <= '0;
      r_frac_pend <= '0;
`endif
    end else begin
      if (w_apply) begin
        r_div_q  <= r_div_pend;
`ifdef BAUD_FRAC_EN
        r_frac_q <= r_frac_pend;
`endif
      end
      if (bus.div_wr) begin
        r_div_pend  <= clamp_div(bus.div_data);
`ifdef BAUD_FRAC_EN
        r_frac_pend <= bus.div_frac;
`endif
        r_busy      <= 1'b1;
        if (bus.div_data < DIV_MIN) begin
          r_cfg_err <= 1'b1;
        end
      end else if (w_apply) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.os_tick  = r_ticks.os;
  assign bus.mid_tick = r_ticks.mid;
  assign bus.bit_tick = r_ticks.bnd;
  assign bus.div_busy = r_busy;
  assign bus.cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Bench for baud_tick_generator: directed timing checks plus randomized traffic against a
// cycle-level behavioural model.
module tb_baud_tick_generator;

  localparam int OS = 16;
  localparam int FW = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  baud_tick_generator_if #(.DIV_WIDTH(16), .FRAC_WIDTH(FW)) bif ();

  baud_tick_generator dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: elapsed cycles in the current oversample period, oversample periods
  // completed in the current bit, and the divisor bookkeeping, all as plain integers.
  int m_div, m_pend, m_frac, m_pfrac, m_el, m_k, m_acc, m_len;
  bit m_busy, m_err, m_os, m_mid, m_bit, m_wrap, m_bnd, m_apply;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div = 651; m_pend = 651; m_frac = 0; m_pfrac = 0;
      m_el = 0; m_k = 0; m_acc = 0;
      m_busy = 0; m_err = 0; m_os = 0; m_mid = 0; m_bit = 0;
    end else begin
      m_len = m_div;
`ifdef BAUD_FRAC_EN
      if (m_acc + m_frac >= (1 << FW)) m_len = m_len + 1;
`endif
      m_wrap  = bif.en && !bif.resync && (m_el + 1 >= m_len);
      m_bnd   = m_wrap && (m_k == OS - 1);
      m_apply = m_busy && (m_bnd || bif.resync || !bif.en);
      m_os    = m_wrap;
      m_mid   = m_wrap && (m_k == OS / 2 - 1);
      m_bit   = m_bnd;
      if (bif.resync) begin
        m_el = 0; m_k = 0; m_acc = 0;
      end else if (m_wrap) begin
        m_el = 0; m_k = (m_k + 1) % OS; m_acc = (m_acc + m_frac) % (1 << FW);
      end else if (bif.en) begin
        m_el = m_el + 1;
      end
      if (m_apply) begin
        m_div = m_pend; m_frac = m_pfrac;
      end
      if (bif.div_wr) begin
        m_pend  = (bif.div_data < 2) ? 2 : int'(bif.div_data);
        m_pfrac = int'(bif.div_frac);
        m_busy  = 1;
        if (bif.div_data < 2) m_err = 1;
      end else if (m_apply) begin
        m_busy = 0;
      end
    end
  end

  // Every cycle out of reset, all five outputs must match the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [4:0] got, want;
      got  = {bif.os_tick, bif.mid_tick, bif.bit_tick, bif.div_busy, bif.cfg_err};
      want = {m_os, m_mid, m_bit, m_busy, m_err};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model_compare cycle=%0d os/mid/bit/busy/err got=%b want=%b", cyc, got, want);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // which: 0=os_tick 1=mid_tick 2=bit_tick; returns cyc of next high sample, -1 on timeout.
  task automatic wait_sig(input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && bif.os_tick) || (which == 1 && bif.mid_tick) ||
          (which == 2 && bif.bit_tick)) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic write_div(input int d, input int f);
    bif.div_data = 16'(d);
    bif.div_frac = FW'(f);
    bif.div_wr   = 1'b1;
    @(negedge clk);
    bif.div_wr   = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int t0, t, t2, tm, tr, tb, n;
    cyc = 0; total = 0; bad = 0;
    rst_n = 1'b0;
    bif.en = 1'b0; bif.resync = 1'b0; bif.div_wr = 1'b0;
    bif.div_data = '0; bif.div_frac = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({bif.os_tick, bif.mid_tick, bif.bit_tick, bif.div_busy, bif.cfg_err}), 0);

    // Default divisor timing from reset release.
    bif.en = 1'b1;
    rst_n  = 1'b1;
    t0     = cyc;
    wait_sig(0, 2000, t);  chk("first_os", t - t0, 651);
    wait_sig(1, 6000, t);  chk("first_mid", t - t0, 5208);
    wait_sig(2, 6000, t);  chk("first_bit", t - t0, 10416);
    tb = t;
    wait_sig(1, 6000, t);  chk("mid_after_bit", t - tb, 5208);
    tm = t;

    // Pause mid-bit: nothing ticks and the boundary slips by the pause length.
    repeat (500) @(negedge clk);
    bif.en = 1'b0;
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bif.os_tick || bif.mid_tick || bif.bit_tick) n++;
    end
    bif.en = 1'b1;
    chk("ticks_while_paused", n, 0);
    wait_sig(2, 8000, t);  chk("bit_after_pause", t - tm, 5208 + 1000);

    // Resync landing exactly on an oversample wrap: that tick is dropped, phase restarts.
    wait_sig(0, 1000, t);
    repeat (650) @(negedge clk);
    bif.resync = 1'b1;
    @(negedge clk);
    bif.resync = 1'b0;
    tr = cyc;
    chk("no_os_on_resync", int'(bif.os_tick), 0);

    // Divisor write mid-bit stays pending until the boundary.
    repeat (2000) @(negedge clk);
    write_div(100, 0);
    chk("busy_after_write", int'(bif.div_busy), 1);
    wait_sig(1, 6000, t);  chk("mid_after_resync", t - tr, 5208);
    chk("busy_mid_bit", int'(bif.div_busy), 1);
    wait_sig(2, 8000, t);  chk("bit_after_resync_old_div", t - tr, 10416);
    chk("busy_clear_at_boundary", int'(bif.div_busy), 0);
    tb = t;
    wait_sig(0, 200, t);   chk("os_period_100", t - tb, 100);
    wait_sig(2, 2000, t);  chk("bit_period_1600", t - tb, 1600);

    // Too-small divisor: clamped to 2, error is sticky; applied at once while stopped.
    write_div(1, 0);
    chk("cfg_err_set", int'(bif.cfg_err), 1);
    bif.en = 1'b0;
    @(negedge clk);
    bif.en = 1'b1;
    chk("busy_clear_idle_apply", int'(bif.div_busy), 0);
    wait_sig(0, 200, t);
    wait_sig(0, 10, t2);   chk("os_period_2", t2 - t, 2);
    wait_sig(2, 100, t);
    write_div(50, 0);
    chk("cfg_err_sticky", int'(bif.cfg_err), 1);

    // Asynchronous reset mid-bit with a write pending.
    @(posedge clk);
    #3;
    chk("busy_before_reset", int'(bif.div_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", int'(bif.div_busy), 0);
    chk("async_reset_err", int'(bif.cfg_err), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    wait_sig(0, 2000, t);  chk("os_after_reset", t - t0, 651);

    // Randomized traffic with short divisors, checked cycle by cycle against the model.
    for (int i = 0; i < 5000; i++) begin
      bif.en       = ($urandom_range(0, 99) < 85);
      bif.resync   = ($urandom_range(0, 99) < 2);
      bif.div_wr   = ($urandom_range(0, 99) < 3);
      bif.div_data = 16'($urandom_range(0, 7));
      bif.div_frac = FW'($urandom_range(0, 15));
      @(negedge clk);
    end
    bif.resync = 1'b0;
    bif.div_wr = 1'b0;
    bif.en     = 1'b1;

`ifdef BAUD_FRAC_EN
    // Fractional divisor 651 + 8/16: periods alternate 651/652.
    rst_n = 1'b0;
    bif.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    write_div(651, 8);
    @(negedge clk);
    bif.en     = 1'b1;
    bif.resync = 1'b1;
    @(negedge clk);
    bif.resync = 1'b0;
    tr = cyc;
    wait_sig(0, 1000, t);   chk("frac_os_first", t - tr, 651);
    wait_sig(0, 1000, t2);  chk("frac_os_second", t2 - t, 652);
    wait_sig(2, 12000, t);  chk("frac_bit_period", t - tr, 10424);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
